// File: rtl/debouncer_pkg.sv
// Shared constants and the glitch-window helper for the push-button debouncer.
package debouncer_pkg;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // Stable-time window in clock cycles, rounded up, never below one cycle.
    function automatic int unsigned glitch_cycles(input int unsigned freq_mhz,
                                                  input int unsigned time_ns);
        int unsigned c;
        c = (freq_mhz * time_ns + 32'd999) / 32'd1000;
        return (c == 0) ? 32'd1 : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for one asynchronous level.
// Latency: 2 cycles. Backpressure: none, free-running.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic sync0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync0 <= RESET_VAL;
            q_o   <= RESET_VAL;
        end else begin
            sync0 <= d_i;
            q_o   <= sync0;
        end
    end

endmodule

// File: rtl/debouncer.sv
// Purpose: debounce an active-low button, one-cycle strobe per accepted press
// (DEBOUNCER_RELEASE_STB_EN adds a release strobe). Latency: GLITCH_CYCLES+2 edges.
// Backpressure: none; strobes are fire-and-forget.
module debouncer
    import debouncer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ   = 150,
    parameter int unsigned GLITCH_TIME_NS = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic key_pressed_stb_o
`ifdef DEBOUNCER_RELEASE_STB_EN
    ,
    output logic key_released_stb_o
`endif
);

    localparam int unsigned GLITCH_CYCLES = glitch_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);
    localparam int          CNT_W         = $clog2(GLITCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYCLES - 1);

    logic             key_s;
    logic             key_state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    sync_2ff #(
        .RESET_VAL (KEY_RELEASED)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (key_i),
        .q_o   (key_s)
    );

    // The new level has differed from the accepted one for the whole window.
    assign accept = (key_s != key_state) && (cnt == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_state         <= KEY_RELEASED;
            cnt               <= '0;
            key_pressed_stb_o <= 1'b0;
        end else begin
            key_pressed_stb_o <= accept && (key_state == KEY_RELEASED);
            if (key_s == key_state) begin
                cnt <= '0;
            end else if (accept) begin
                key_state <= key_s;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DEBOUNCER_RELEASE_STB_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_released_stb_o <= 1'b0;
        end else begin
            key_released_stb_o <= accept && (key_state == KEY_PRESSED);
        end
    end
`endif

endmodule

// File: tb/tb_debouncer.sv
// Directed vector bench for debouncer at default parameters (15-cycle window).
module tb_debouncer;

    logic clk_i = 1'b0;
    logic rst_i;
    logic key_i;
    logic key_pressed_stb_o;
`ifdef DEBOUNCER_RELEASE_STB_EN
    logic key_released_stb_o;
`endif

    always #5 clk_i = ~clk_i;

    debouncer dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .key_i             (key_i),
        .key_pressed_stb_o (key_pressed_stb_o)
`ifdef DEBOUNCER_RELEASE_STB_EN
        ,
        .key_released_stb_o(key_released_stb_o)
`endif
    );

    typedef struct {
        logic key;
        logic exp_press;
        logic exp_rel;
    } vec_t;

    vec_t vec[600];
    int   n;
    int   errors;
    int   checks;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic seg(input logic k, input int len);
        for (int i = 0; i < len; i++) begin
            vec[n].key       = k;
            vec[n].exp_press = 1'b0;
            vec[n].exp_rel   = 1'b0;
            n++;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_rel(input string name, input logic exp);
`ifdef DEBOUNCER_RELEASE_STB_EN
        check(name, key_released_stb_o, exp);
`else
        if (exp) $display("note: %s release strobe not built", name);
`endif
    endtask

    initial begin
        int p;
        errors = 0;
        checks = 0;
        n      = 0;

        // Press strobe appears 16 vectors after the key level goes low; release symmetric.
        seg(1'b1, 50);
        seg(1'b0, 5);  seg(1'b1, 10);
        seg(1'b0, 14); seg(1'b1, 20);
        p = n; seg(1'b0, 15); seg(1'b1, 40);
        vec[p+16].exp_press = 1'b1;
        vec[p+31].exp_rel   = 1'b1;
        p = n; seg(1'b0, 100);
        vec[p+16].exp_press = 1'b1;
        seg(1'b1, 1);  seg(1'b0, 35);
        p = n; seg(1'b1, 20);
        vec[p+16].exp_rel   = 1'b1;
        p = n; seg(1'b0, 20);
        vec[p+16].exp_press = 1'b1;
        p = n; seg(1'b1, 20);
        vec[p+16].exp_rel   = 1'b1;
        seg(1'b0, 10); seg(1'b1, 1);
        p = n; seg(1'b0, 20);
        vec[p+16].exp_press = 1'b1;
        p = n; seg(1'b1, 20);
        vec[p+16].exp_rel   = 1'b1;

        // Reset with an unknown key level; it must not leak out.
        rst_i = 1'b1;
        key_i = 1'bx;
        repeat (3) tick();
        check("reset_stb", key_pressed_stb_o, 1'b0);
`ifdef DEBOUNCER_RELEASE_STB_EN
        check("reset_rel_stb", key_released_stb_o, 1'b0);
`endif
        key_i = 1'b1;
        tick();
        rst_i = 1'b0;

        for (int i = 0; i < n; i++) begin
            key_i = vec[i].key;
            tick();
            check($sformatf("vec%0d_press", i), key_pressed_stb_o, vec[i].exp_press);
`ifdef DEBOUNCER_RELEASE_STB_EN
            check($sformatf("vec%0d_rel", i), key_released_stb_o, vec[i].exp_rel);
`endif
        end

        // Reset mid-count discards progress; held key strobes after the full latency.
        key_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("precnt%0d", k), key_pressed_stb_o, 1'b0);
        end
        #2 rst_i = 1'b1;
        #1 check("midrst_stb", key_pressed_stb_o, 1'b0);
        repeat (3) @(posedge clk_i);
        #3 rst_i = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("postrst_e%0d", k), key_pressed_stb_o, (k == 17));
            check_rel($sformatf("postrst_rel_e%0d", k), 1'b0);
        end

        // Release after an accepted press.
        key_i = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            check($sformatf("release_press_e%0d", k), key_pressed_stb_o, 1'b0);
`ifdef DEBOUNCER_RELEASE_STB_EN
            check($sformatf("release_e%0d", k), key_released_stb_o, (k == 17));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
